// File: rtl/ram_rw_pkg.sv
// Shared types for the ram host-port initiator: opcodes, FSM states, header layout, lane helper.
// No logic of its own; imported by ram_rw_ctl.
package ram_rw_pkg;

  typedef enum logic [7:0] {
    OP_WR_IRAM = 8'h01,
    OP_WR_DRAM = 8'h02,
    OP_RD_IRAM = 8'h03,
    OP_RD_DRAM = 8'h04
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WR_DATA,
    ST_WR_STB,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RD_TX,
    ST_ACK
  } state_t;

  // Bytes arrive little-endian and are shifted in from the top, so the
  // first byte ends up in addr[7:0] and the last in len[15:8].
  typedef struct packed {
    logic [15:0] len;
    logic [31:0] addr;
  } hdr_t;

  localparam logic [7:0] ACK_BYTE = 8'h06;

  function automatic logic [3:0] byte_lane_en(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/ram_rw_ctl.sv
// Byte-stream command frames -> byte-wide IRAM/DRAM host-port writes/reads; 2 cycles per ram byte.
// rx_rdy_o low during strobe/read/ACK; tx_vld_o held until tx_rdy_i, which stalls the frame.
module ram_rw_ctl
  import ram_rw_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_vld_i,
  output logic            rx_rdy_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_vld_o,
  input  logic            tx_rdy_i,
  output logic            iram_rd_sel_o,
  output logic            iram_wr_sel_o,
  output logic            dram_rd_sel_o,
  output logic            dram_wr_sel_o,
  output logic [XLEN-1:0] ram_rd_addr_o,
  output logic [XLEN-1:0] ram_wr_addr_o,
  output logic [XLEN-1:0] ram_wr_data_o,
  output logic [3:0]      ram_wr_byte_en_o,
  input  logic [7:0]      ram_rd_data_i,
  output logic            busy_o,
  output logic            err_o
);

  state_t      state_q, state_d;
  opcode_t     op_q, op_d;
  hdr_t        hdr_q, hdr_d, hdr_nxt;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  wr_byte_q, wr_byte_d;
  logic [7:0]  tx_dat_q, tx_dat_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        rx_rdy_q, rx_rdy_d;
  logic        err_q, err_d;

  logic rx_fire, is_dram, is_wr, waiting_rx, timeout_hit;

  assign rx_fire     = rx_vld_i & rx_rdy_q;
  assign is_dram     = (op_q == OP_WR_DRAM) || (op_q == OP_RD_DRAM);
  assign is_wr       = (op_q == OP_WR_IRAM) || (op_q == OP_WR_DRAM);
  assign hdr_nxt     = {rx_data_i, hdr_q[47:8]};
  assign waiting_rx  = (state_q == ST_HDR) || (state_q == ST_WR_DATA);
  assign timeout_hit = (TIMEOUT_CYC != 0) && waiting_rx && !rx_fire &&
                       (to_cnt_q == 32'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    hdr_d            = hdr_q;
    hdr_cnt_d        = hdr_cnt_q;
    addr_d           = addr_q;
    len_d            = len_q;
    wr_byte_d        = wr_byte_q;
    tx_dat_d         = tx_dat_q;
    err_d            = 1'b0;
    to_cnt_d         = (waiting_rx && !rx_fire) ? to_cnt_q + 32'd1 : 32'd0;
    iram_rd_sel_o    = 1'b0;
    iram_wr_sel_o    = 1'b0;
    dram_rd_sel_o    = 1'b0;
    dram_wr_sel_o    = 1'b0;
    ram_rd_addr_o    = '0;
    ram_wr_addr_o    = '0;
    ram_wr_data_o    = '0;
    ram_wr_byte_en_o = 4'b0000;
    tx_data_o        = 8'h00;
    tx_vld_o         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (rx_data_i inside {OP_WR_IRAM, OP_WR_DRAM, OP_RD_IRAM, OP_RD_DRAM}) begin
            op_d      = opcode_t'(rx_data_i);
            hdr_cnt_d = 3'd0;
            state_d   = ST_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (rx_fire) begin
          hdr_d     = hdr_nxt;
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == 3'd5) begin
            addr_d = hdr_nxt.addr;
            len_d  = hdr_nxt.len;
            if (is_wr) state_d = (hdr_nxt.len == 16'd0) ? ST_ACK : ST_WR_DATA;
            else       state_d = (hdr_nxt.len == 16'd0) ? ST_IDLE : ST_RD_ADDR;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (rx_fire) begin
          wr_byte_d = rx_data_i;
          state_d   = ST_WR_STB;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_STB: begin
        iram_wr_sel_o    = !is_dram;
        dram_wr_sel_o    = is_dram;
        ram_wr_addr_o    = XLEN'(addr_q);
        ram_wr_data_o    = XLEN'({4{wr_byte_q}});
        ram_wr_byte_en_o = byte_lane_en(addr_q[1:0]);
        addr_d           = addr_q + 32'd1;
        len_d            = len_q - 16'd1;
        state_d          = (len_q == 16'd1) ? ST_ACK : ST_WR_DATA;
      end
      ST_RD_ADDR: begin
        iram_rd_sel_o = !is_dram;
        dram_rd_sel_o = is_dram;
        ram_rd_addr_o = XLEN'(addr_q);
        state_d       = ST_RD_DATA;
      end
      // The ram's byte mux follows sel, so sel stays up while its data is captured.
      ST_RD_DATA: begin
        iram_rd_sel_o = !is_dram;
        dram_rd_sel_o = is_dram;
        ram_rd_addr_o = XLEN'(addr_q);
        tx_dat_d      = ram_rd_data_i;
        state_d       = ST_RD_TX;
      end
      ST_RD_TX: begin
        tx_data_o = tx_dat_q;
        tx_vld_o  = 1'b1;
        if (tx_rdy_i) begin
          addr_d  = addr_q + 32'd1;
          len_d   = len_q - 16'd1;
          state_d = (len_q == 16'd1) ? ST_IDLE : ST_RD_ADDR;
        end
      end
      ST_ACK: begin
        tx_data_o = ACK_BYTE;
        tx_vld_o  = 1'b1;
        if (tx_rdy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rx_rdy_d = (state_d == ST_IDLE) || (state_d == ST_HDR) || (state_d == ST_WR_DATA);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_WR_IRAM;
      hdr_q     <= '0;
      hdr_cnt_q <= 3'd0;
      addr_q    <= 32'd0;
      len_q     <= 16'd0;
      wr_byte_q <= 8'h00;
      tx_dat_q  <= 8'h00;
      to_cnt_q  <= 32'd0;
      rx_rdy_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hdr_q     <= hdr_d;
      hdr_cnt_q <= hdr_cnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_byte_q <= wr_byte_d;
      tx_dat_q  <= tx_dat_d;
      to_cnt_q  <= to_cnt_d;
      rx_rdy_q  <= rx_rdy_d;
      err_q     <= err_d;
    end
  end

  assign rx_rdy_o = rx_rdy_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign err_o    = err_q;

endmodule

// File: tb/tb_ram_rw_ctl.sv
// Scoreboard bench for ram_rw_ctl: directed frames plus random traffic against a byte-addressed
// memory reference; a monitor pops expected ram accesses and tx bytes as the DUT presents them.
module tb_ram_rw_ctl;
  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst_n_i;
  logic [7:0]      rx_data_i;
  logic            rx_vld_i;
  logic            rx_rdy_o;
  logic [7:0]      tx_data_o;
  logic            tx_vld_o;
  logic            tx_rdy_i;
  logic            iram_rd_sel_o, iram_wr_sel_o, dram_rd_sel_o, dram_wr_sel_o;
  logic [XLEN-1:0] ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o;
  logic [3:0]      ram_wr_byte_en_o;
  logic [7:0]      ram_rd_data_i;
  logic            busy_o, err_o;

  always #5 clk = ~clk;

  ram_rw_ctl #(.XLEN(XLEN), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .rx_data_i(rx_data_i), .rx_vld_i(rx_vld_i), .rx_rdy_o(rx_rdy_o),
    .tx_data_o(tx_data_o), .tx_vld_o(tx_vld_o), .tx_rdy_i(tx_rdy_i),
    .iram_rd_sel_o(iram_rd_sel_o), .iram_wr_sel_o(iram_wr_sel_o),
    .dram_rd_sel_o(dram_rd_sel_o), .dram_wr_sel_o(dram_wr_sel_o),
    .ram_rd_addr_o(ram_rd_addr_o), .ram_wr_addr_o(ram_wr_addr_o),
    .ram_wr_data_o(ram_wr_data_o), .ram_wr_byte_en_o(ram_wr_byte_en_o),
    .ram_rd_data_i(ram_rd_data_i), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct { bit dram; logic [31:0] addr; logic [7:0] dat; } wr_exp_t;
  typedef struct { bit dram; logic [31:0] addr; } rd_exp_t;

  wr_exp_t    wr_q[$];
  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] pay[$];

  logic [7:0] iram_mem[logic [31:0]], dram_mem[logic [31:0]];
  logic [7:0] ref_iram[logic [31:0]], ref_dram[logic [31:0]];
  logic [7:0] ram_rd_q = 8'h00;

  int n_cmp = 0, n_bad = 0, err_seen = 0, err_exp = 0, rd_run = 0;
  bit hold_tx = 1'b0, rd_prev = 1'b0, err_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Contents the ram holds before anything is written.
  function automatic logic [7:0] preload(bit dram, logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ (dram ? 8'hA5 : 8'h3C);
  endfunction

  function automatic logic [7:0] ref_rd(bit dram, logic [31:0] a);
    if (dram) return ref_dram.exists(a) ? ref_dram[a] : preload(1'b1, a);
    return ref_iram.exists(a) ? ref_iram[a] : preload(1'b0, a);
  endfunction

  function automatic logic [7:0] mem_rd(bit dram, logic [31:0] a);
    if (dram) return dram_mem.exists(a) ? dram_mem[a] : preload(1'b1, a);
    return iram_mem.exists(a) ? iram_mem[a] : preload(1'b0, a);
  endfunction

  function automatic logic [127:0] all_outs();
    return {rx_rdy_o, tx_vld_o, tx_data_o, iram_rd_sel_o, iram_wr_sel_o, dram_rd_sel_o,
            dram_wr_sel_o, ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_byte_en_o,
            busy_o, err_o};
  endfunction

  // Behavioural ram: byte-lane writes, one-cycle registered read.
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (iram_wr_sel_o && ram_wr_byte_en_o[l])
        iram_mem[{ram_wr_addr_o[31:2], 2'(l)}] = ram_wr_data_o[8*l +: 8];
      if (dram_wr_sel_o && ram_wr_byte_en_o[l])
        dram_mem[{ram_wr_addr_o[31:2], 2'(l)}] = ram_wr_data_o[8*l +: 8];
    end
    if (iram_rd_sel_o)      ram_rd_q <= mem_rd(1'b0, ram_rd_addr_o);
    else if (dram_rd_sel_o) ram_rd_q <= mem_rd(1'b1, ram_rd_addr_o);
  end
  assign ram_rd_data_i = ram_rd_q;

  always @(posedge clk) begin
    #1 tx_rdy_i = hold_tx ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst_n_i === 1'b1) begin
      logic    rd_any;
      wr_exp_t we;
      rd_exp_t re;
      logic [7:0] te;
      rd_any = iram_rd_sel_o | dram_rd_sel_o;
      if (iram_rd_sel_o | iram_wr_sel_o | dram_rd_sel_o | dram_wr_sel_o)
        check("sel_onehot", $countones({iram_rd_sel_o, iram_wr_sel_o, dram_rd_sel_o, dram_wr_sel_o}), 1);
      if (iram_wr_sel_o | dram_wr_sel_o) begin
        if (wr_q.size() == 0) check("unexpected_wr", ram_wr_addr_o, 128'hx);
        else begin
          we = wr_q.pop_front();
          check("ram_wr", {dram_wr_sel_o, iram_wr_sel_o, ram_wr_byte_en_o, ram_wr_addr_o, ram_wr_data_o},
                {we.dram, !we.dram, 4'(4'b0001 << we.addr[1:0]), we.addr, {4{we.dat}}});
        end
      end
      if (rd_any && !rd_prev) begin
        if (rd_q.size() == 0) check("unexpected_rd", ram_rd_addr_o, 128'hx);
        else begin
          re = rd_q.pop_front();
          check("ram_rd", {dram_rd_sel_o, iram_rd_sel_o, ram_rd_addr_o}, {re.dram, !re.dram, re.addr});
        end
      end
      if (!rd_any && rd_prev) check("rd_sel_cycles", rd_run, 2);
      rd_run  = rd_any ? rd_run + 1 : 0;
      rd_prev = rd_any;
      if (tx_vld_o && tx_rdy_i) begin
        if (tx_q.size() == 0) check("unexpected_tx", tx_data_o, 128'hx);
        else begin
          te = tx_q.pop_front();
          check("tx_byte", tx_data_o, te);
        end
      end
      if (err_o) begin
        err_seen++;
        if (err_prev) check("err_pulse_width", 2, 1);
      end
      err_prev = err_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 1)) @(posedge clk);
    @(posedge clk); #1;
    rx_data_i = b;
    rx_vld_i  = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_rdy_o || n > 2000) break;
      n++;
    end
    @(posedge clk); #1;
    rx_vld_i = 1'b0;
    if (n > 2000) check("rx_handshake_timeout", n, 0);
  endtask

  // Pushes the expected ram accesses / tx bytes, then sends the frame (payload from pay[]).
  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input int len);
    bit dram = (op == 8'h02) || (op == 8'h04);
    bit wr   = (op == 8'h01) || (op == 8'h02);
    logic [31:0] a;
    logic [15:0] l16 = 16'(len);
    for (int i = 0; i < len; i++) begin
      a = addr + 32'(i);
      if (wr) begin
        wr_q.push_back('{dram, a, pay[i]});
        if (dram) ref_dram[a] = pay[i]; else ref_iram[a] = pay[i];
      end else begin
        rd_q.push_back('{dram, a});
        tx_q.push_back(ref_rd(dram, a));
      end
    end
    if (wr) tx_q.push_back(8'h06);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    send_byte(l16[7:0]);
    send_byte(l16[15:8]);
    if (wr) for (int i = 0; i < len; i++) send_byte(pay[i]);
  endtask

  task automatic drain();
    int n = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0 || tx_q.size() != 0 || busy_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_queues_busy", {32'(wr_q.size()), 32'(rd_q.size()), 32'(tx_q.size()), 31'd0, busy_o}, 128'd0);
    check("err_count", err_seen, err_exp);
  endtask

  initial begin
    logic [7:0]  cap;
    logic [31:0] base;
    rst_n_i = 1'b0; rx_vld_i = 1'b0; rx_data_i = 8'h00; tx_rdy_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 128'd0);
    @(posedge clk); #1 rst_n_i = 1'b1;

    pay = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(8'h01, 32'h0000_0010, 3);
    drain();
    send_frame(8'h04, 32'h0002_0003, 2);
    drain();

    hold_tx = 1'b1;
    repeat (2) @(posedge clk);
    send_frame(8'h03, 32'h0000_0010, 3);
    for (int n = 0; n < 200 && !tx_vld_o; n++) @(negedge clk);
    cap = tx_data_o;
    check("stall_tx_vld", tx_vld_o, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("stall_stable", {tx_vld_o, tx_data_o, iram_rd_sel_o, iram_wr_sel_o, dram_rd_sel_o,
                             dram_wr_sel_o, err_o}, {1'b1, cap, 5'b0});
    end
    hold_tx = 1'b0;
    drain();

    err_exp++;
    send_byte(8'h7F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bad_op_busy", busy_o, 1'b0);
    end
    pay = '{8'h5E};
    send_frame(8'h02, 32'h0000_0200, 1);
    drain();

    err_exp++;
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'h44);
    repeat (TO + 10) @(negedge clk);
    check("timeout_idle", {busy_o, rx_rdy_o}, 2'b01);
    drain();

    pay.delete();
    for (int i = 0; i < 4; i++) pay.push_back(8'($urandom));
    send_byte(8'h01);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h04); send_byte(8'h00);
    wr_q.push_back('{1'b0, 32'h40, pay[0]});
    send_byte(pay[0]);
    @(negedge clk);
    check("strobe_before_reset", iram_wr_sel_o, 1'b1);
    #1 rst_n_i = 1'b0;
    #1 check("reset_mid_frame", all_outs(), 128'd0);
    repeat (3) @(posedge clk);
    #1 rst_n_i = 1'b1;
    repeat (20) @(negedge clk);
    drain();
    pay.delete();
    send_frame(8'h02, 32'h0000_0100, 0);
    drain();

    for (int f = 0; f < 40; f++) begin
      logic [7:0] op;
      int len;
      op = 8'($urandom_range(1, 4));
      case ($urandom_range(0, 2))
        0:       base = 32'h0000_0010;
        1:       base = 32'h0002_0000;
        default: base = 32'hFFFF_FFF8;
      endcase
      len = $urandom_range(0, 6);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      send_frame(op, base + 32'($urandom_range(0, 15)), len);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
